dice_turn_ctrl: RTL and testbench

Two-player turn scheduler for the shared die roller. It owns the roller's `enable` and `btn` inputs, routes exactly one player's button at a time, and captures each settled roll when the roller raises `choose`. It scores each round and declares a match winner. It sits between the board buttons and the single roller instance in the lab top level.

---
 rtl/dice_pkg.sv | 29 ++
 rtl/dice_turn_ctrl_turn_timer.sv | 30 +++
 rtl/dice_turn_ctrl.sv | 154 +++++++++++++++
 tb/tb_dice_turn_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dice_pkg.sv
// Shared types and constants for the two-player dice turn controller.
package dice_pkg;

    // Controller states: one turn and one roller-clear state per player.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TURN_A = 3'd1,
        CLR_A  = 3'd2,
        TURN_B = 3'd3,
        CLR_B  = 3'd4,
        JUDGE  = 3'd5,
        DONE   = 3'd6
    } dice_state_t;

    localparam int DIE_W = 3;
    localparam logic [DIE_W-1:0] DIE_MIN = 3'd1;
    localparam logic [DIE_W-1:0] DIE_MAX = 3'd6;

    // One-hot player encoding shared by the active and winner outputs.
    localparam logic [1:0] PLAYER_NONE = 2'b00;
    localparam logic [1:0] PLAYER_A    = 2'b01;
    localparam logic [1:0] PLAYER_B    = 2'b10;

    // A settled roll is only meaningful inside the die face range.
    function automatic logic valid_roll(input logic [DIE_W-1:0] v);
        return (v >= DIE_MIN) && (v <= DIE_MAX);
    endfunction

endpackage

// File: rtl/dice_turn_ctrl_turn_timer.sv
// Per-turn forfeit counter. Counts cycles while enabled, holds at the
// last count and flags expiry there. Used only when DICE_CTRL_FORFEIT_EN
// is defined.
module turn_timer #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Count up during a turn, saturating at the expiry value.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/dice_turn_ctrl.sv
// Two-player turn scheduler for the shared die roller.
// Routes one player's button to the roller at a time, captures each settled
// roll, scores the round and declares the match winner.
// Optional feature: define DICE_CTRL_FORFEIT_EN to add a per-turn timeout
// that records a zero roll for a player who does not roll in time.
module dice_turn_ctrl
    import dice_pkg::*;
#(
    parameter int WIN_SCORE      = 3,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              btn_a,
    input  logic              btn_b,
    input  logic [DIE_W-1:0]  roll_num,
    input  logic              roll_choose,
    output logic              roll_enable,
    output logic              roll_btn,
    output logic [1:0]        active,
    output logic [DIE_W-1:0]  val_a,
    output logic [DIE_W-1:0]  val_b,
    output logic [2:0]        score_a,
    output logic [2:0]        score_b,
    output logic              game_over,
    output logic [1:0]        winner,
    output dice_state_t       state
);

    localparam logic [2:0] WIN  = 3'(WIN_SCORE);
    localparam logic [3:0] WIN4 = {1'b0, WIN};

    logic       capture;
    logic       timeout;
    logic [3:0] next_a;
    logic [3:0] next_b;

    assign capture = roll_choose && valid_roll(roll_num);
    assign next_a  = {1'b0, score_a} + 4'd1;
    assign next_b  = {1'b0, score_b} + 4'd1;

`ifdef DICE_CTRL_FORFEIT_EN
    logic in_turn;
    assign in_turn = (state == TURN_A) || (state == TURN_B);

    // Held clear outside the turns, so every turn starts counting from zero.
    turn_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_turn_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!in_turn),
        .enable  (in_turn),
        .expired (timeout)
    );
`else
    assign timeout = 1'b0;

    // TIMEOUT_CYCLES only matters with the forfeit timer; zero is never legal.
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
    end
`endif

    // Roller controls are combinational so a press reaches the roller at once.
    always_comb begin
        roll_enable = 1'b0;
        roll_btn    = 1'b0;
        active      = PLAYER_NONE;
        case (state)
            TURN_A: begin
                roll_enable = 1'b1;
                roll_btn    = btn_a;
                active      = PLAYER_A;
            end
            TURN_B: begin
                roll_enable = 1'b1;
                roll_btn    = btn_b;
                active      = PLAYER_B;
            end
            default: ;
        endcase
    end

    // Match FSM with registered values, scores and result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            val_a     <= '0;
            val_b     <= '0;
            score_a   <= '0;
            score_b   <= '0;
            game_over <= 1'b0;
            winner    <= PLAYER_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state <= TURN_A;
                end
                TURN_A: begin
                    if (capture) begin
                        val_a <= roll_num;
                        state <= CLR_A;
                    end else if (timeout) begin
                        val_a <= '0;
                        state <= CLR_A;
                    end
                end
                CLR_A: state <= TURN_B;
                TURN_B: begin
                    if (capture) begin
                        val_b <= roll_num;
                        state <= CLR_B;
                    end else if (timeout) begin
                        val_b <= '0;
                        state <= CLR_B;
                    end
                end
                CLR_B: state <= JUDGE;
                JUDGE: begin
                    state <= TURN_A;
                    if (val_a > val_b) begin
                        if (score_a < WIN) score_a <= next_a[2:0];
                        if (next_a >= WIN4) begin
                            game_over <= 1'b1;
                            winner    <= PLAYER_A;
                            state     <= DONE;
                        end
                    end else if (val_b > val_a) begin
                        if (score_b < WIN) score_b <= next_b[2:0];
                        if (next_b >= WIN4) begin
                            game_over <= 1'b1;
                            winner    <= PLAYER_B;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (btn_a && btn_b) begin
                        state     <= IDLE;
                        val_a     <= '0;
                        val_b     <= '0;
                        score_a   <= '0;
                        score_b   <= '0;
                        game_over <= 1'b0;
                        winner    <= PLAYER_NONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dice_turn_ctrl.sv
// Self-checking bench for dice_turn_ctrl: directed rounds plus a random
// match, checked against a round-level scoring model.
module tb_dice_turn_ctrl;
    import dice_pkg::*;

    localparam int WIN = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        btn_a;
    logic        btn_b;
    logic [2:0]  roll_num;
    logic        roll_choose;
    logic        roll_enable;
    logic        roll_btn;
    logic [1:0]  active;
    logic [2:0]  val_a;
    logic [2:0]  val_b;
    logic [2:0]  score_a;
    logic [2:0]  score_b;
    logic        game_over;
    logic [1:0]  winner;
    dice_state_t state;

    int n_checks = 0;
    int n_pass   = 0;

    // Round-level model: match scores and result.
    int m_sa = 0;
    int m_sb = 0;
    logic [2:0] exp_q[$];

    dice_turn_ctrl #(
        .WIN_SCORE      (WIN),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .btn_a       (btn_a),
        .btn_b       (btn_b),
        .roll_num    (roll_num),
        .roll_choose (roll_choose),
        .roll_enable (roll_enable),
        .roll_btn    (roll_btn),
        .active      (active),
        .val_a       (val_a),
        .val_b       (val_b),
        .score_a     (score_a),
        .score_b     (score_b),
        .game_over   (game_over),
        .winner      (winner),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic idle_inputs();
        btn_a = 1'b0; btn_b = 1'b0; roll_choose = 1'b0; roll_num = 3'd0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, int'(state), int'(IDLE));
        check({tag, "_en"}, roll_enable, 0);
        check({tag, "_rbtn"}, roll_btn, 0);
        check({tag, "_active"}, active, 0);
        check({tag, "_val_a"}, val_a, 0);
        check({tag, "_val_b"}, val_b, 0);
        check({tag, "_score_a"}, score_a, 0);
        check({tag, "_score_b"}, score_b, 0);
        check({tag, "_over"}, game_over, 0);
        check({tag, "_winner"}, winner, 0);
    endtask

    // From IDLE, pulse start and expect A's turn on the next cycle.
    task automatic start_match();
        m_sa = 0; m_sb = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_turn_a", int'(state), int'(TURN_A));
    endtask

    // Called at a negedge inside TURN_x. Wiggles buttons and issues ignored
    // strobes for 'delay' cycles, then rolls 'v'. Returns one cycle after
    // the clear cycle.
    task automatic play_turn(input bit is_a, input logic [2:0] v, input int delay);
        dice_state_t turn_st;
        turn_st = is_a ? TURN_A : TURN_B;
        for (int i = 0; i < delay; i++) begin
            btn_a = 1'($urandom_range(0, 1));
            btn_b = 1'($urandom_range(0, 1));
            roll_choose = ($urandom_range(0, 2) == 0);
            roll_num = roll_choose ? (($urandom_range(0, 1) == 0) ? 3'd0 : 3'd7)
                                   : 3'($urandom_range(0, 7));
            #1;
            check("turn_rbtn", roll_btn, is_a ? btn_a : btn_b);
            check("turn_en", roll_enable, 1);
            check("turn_active", active, is_a ? 1 : 2);
            @(negedge clk);
            check("turn_hold", int'(state), int'(turn_st));
        end
        roll_choose = 1'b1;
        roll_num = v;
        @(negedge clk);
        idle_inputs();
        check("clr_state", int'(state), int'(is_a ? CLR_A : CLR_B));
        check("clr_en", roll_enable, 0);
        check(is_a ? "cap_val_a" : "cap_val_b", is_a ? val_a : val_b, v);
        @(negedge clk);
        check("after_clr", int'(state), int'(is_a ? TURN_B : JUDGE));
        check("after_clr_en", roll_enable, is_a ? 1 : 0);
    endtask

    // At JUDGE: apply the round to the model and check the visible result.
    task automatic judge_check();
        logic [2:0] a, b;
        a = exp_q.pop_front();
        b = exp_q.pop_front();
        if (a > b) m_sa++;
        else if (b > a) m_sb++;
        @(negedge clk);
        check("score_a", score_a, m_sa);
        check("score_b", score_b, m_sb);
        check("game_over", game_over, (m_sa == WIN || m_sb == WIN) ? 1 : 0);
        check("winner", winner, (m_sa == WIN) ? 1 : (m_sb == WIN) ? 2 : 0);
        check("post_judge", int'(state), int'((m_sa == WIN || m_sb == WIN) ? DONE : TURN_A));
    endtask

    task automatic play_round(input logic [2:0] a, input logic [2:0] b, input int da, input int db);
        exp_q.push_back(a);
        exp_q.push_back(b);
        play_turn(1'b1, a, da);
        play_turn(1'b0, b, db);
        judge_check();
    endtask

    // In DONE: start is ignored, both buttons return to a cleared IDLE.
    task automatic leave_done();
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("done_hold", int'(state), int'(DONE));
        check("done_en", roll_enable, 0);
        start = 1'b0;
        btn_a = 1'b1; btn_b = 1'b0;
        @(negedge clk);
        check("done_one_btn", int'(state), int'(DONE));
        btn_b = 1'b1;
        @(negedge clk);
        idle_inputs();
        check_all_zero("exit");
    endtask

    initial begin
        int rounds;
        rst_n = 1'b0; start = 1'b0; idle_inputs();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_hold", int'(state), int'(IDLE));

        // Directed rounds: A wins 5 vs 2, then a 3/3 tie.
        start_match();
        btn_a = 1'b1;
        #1 check("held_btn_a", roll_btn, 1);
        play_round(3'd5, 3'd2, 2, 1);
        play_round(3'd3, 3'd3, 0, 3);

        // Random remainder of the match.
        rounds = 0;
        while (m_sa < WIN && m_sb < WIN && rounds < 60) begin
            play_round(3'($urandom_range(1, 6)), 3'($urandom_range(1, 6)),
                       $urandom_range(0, 4), $urandom_range(0, 4));
            rounds++;
        end
        check("rand_match_done", game_over, 1);
        leave_done();

        // A sweeps three rounds; score stops at the win count.
        start_match();
        for (int r = 0; r < 3; r++) play_round(3'd6, 3'd1, 1, 1);
        check("sweep_score_a", score_a, 3);
        check("sweep_winner", winner, 1);
        leave_done();

`ifdef DICE_CTRL_FORFEIT_EN
        // A never rolls: eight turn cycles, then a zero roll is recorded.
        start_match();
        play_round(3'd5, 3'd5, 0, 0);
        for (int i = 0; i < 8; i++) begin
            check("forfeit_wait", int'(state), int'(TURN_A));
            @(negedge clk);
        end
        check("forfeit_clr", int'(state), int'(CLR_A));
        check("forfeit_val_a", val_a, 0);
        @(negedge clk);
        check("forfeit_turn_b", int'(state), int'(TURN_B));
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd1);
        play_turn(1'b0, 3'd1, 0);
        judge_check();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`endif

        // Reset in the middle of B's turn aborts everything.
        start_match();
        play_turn(1'b1, 3'd4, 1);
        check("pre_reset_turn_b", int'(state), int'(TURN_B));
        btn_b = 1'b1;
        roll_choose = 1'b1;
        roll_num = 3'd6;
        rst_n = 1'b0;
        @(negedge clk);
        idle_inputs();
        check_all_zero("mid_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", int'(state), int'(IDLE));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard stop so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
